// File: rtl/alu_exec_stage.sv
// Single-cycle ALU execute stage with valid/ready handshakes on both sides.
// Define ALU_EXEC_SKID_EN to add a one-entry skid register that decouples in_ready from out_ready.
module alu_exec_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [4:0]  rd_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rd,
  output logic [4:0]  rd_idx_out,
  output logic        illegal
);

  logic [4:0]  w_shamt;
  logic [31:0] w_result;
  logic        w_illegal;
  logic        w_xfer;

  logic        r_out_valid;
  logic [31:0] r_rd;
  logic [4:0]  r_rd_idx;
  logic        r_illegal;

  assign w_shamt = rs2[4:0];

  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (op)
      4'd0:    w_result = rs1 + rs2;
      4'd1:    w_result = rs1 - rs2;
      4'd2:    w_result = rs1 << w_shamt;
      4'd3:    w_result = rs1 >> w_shamt;
      4'd4:    w_result = 32'($signed(rs1) >>> w_shamt);
      4'd5:    w_result = rs1 & rs2;
      4'd6:    w_result = rs1 | rs2;
      4'd7:    w_result = rs1 ^ rs2;
      4'd8:    w_result = {31'd0, $signed(rs1) < $signed(rs2)};
      4'd9:    w_result = {31'd0, rs1 < rs2};
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_xfer     = in_valid && in_ready;
  assign out_valid  = r_out_valid;
  assign rd         = r_rd;
  assign rd_idx_out = r_rd_idx;
  assign illegal    = r_illegal;

`ifdef ALU_EXEC_SKID_EN
  logic        r_skid_valid;
  logic [31:0] r_skid_rd;
  logic [4:0]  r_skid_idx;
  logic        r_skid_illegal;
  logic        w_out_free;

  // Ready depends only on registered skid state (plus reset), never on out_ready.
  assign in_ready   = !rst && !r_skid_valid;
  assign w_out_free = !r_out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      r_rd           <= '0;
      r_rd_idx       <= '0;
      r_illegal      <= 1'b0;
      r_skid_valid   <= 1'b0;
      r_skid_rd      <= '0;
      r_skid_idx     <= '0;
      r_skid_illegal <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_rd         <= r_skid_rd;
        r_rd_idx     <= r_skid_idx;
        r_illegal    <= r_skid_illegal;
        r_skid_valid <= 1'b0;
      end else if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_rd        <= w_result;
        r_rd_idx    <= rd_idx;
        r_illegal   <= w_illegal;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_xfer) begin
      r_skid_valid   <= 1'b1;
      r_skid_rd      <= w_result;
      r_skid_idx     <= rd_idx;
      r_skid_illegal <= w_illegal;
    end
  end
`else
  assign in_ready = !rst && (!r_out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_rd        <= '0;
      r_rd_idx    <= '0;
      r_illegal   <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_rd        <= w_result;
      r_rd_idx    <= rd_idx;
      r_illegal   <= w_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have port: in_valid  input  1  issue-side operand bundle valid.
REQ-004 SHALL have port: in_ready  output  1  stage accepts bundle this cycle.
REQ-005 SHALL have port: op  input  4  operation code.
REQ-006 SHALL have port: rs1  input  32  first operand.
REQ-007 SHALL have port: rs2  input  32  second operand; bits [4:0] are the shift amount.
REQ-008 SHALL have port: rd_idx  input  5  destination register tag.
REQ-009 SHALL have port: out_valid  output  1  result valid to writeback.
REQ-010 SHALL have port: out_ready  input  1  writeback accepts result.
REQ-011 SHALL have port: rd  output  32  result.
REQ-012 SHALL have port: rd_idx_out  output  5  tag travelling with rd.
REQ-013 SHALL have port: illegal  output  1  qualified by out_valid; op was not a defined code.

Function
REQ-014 SHALL accept a bundle on a posedge where in_valid && in_ready are both high ("transfer").
REQ-015 SHALL decode op as follows: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 AND, 6 OR, 7 XOR, 8 SLT (signed, result 0/1), 9 SLTU (unsigned, result 0/1).
REQ-016 SHALL compute ADD/SUB modulo 2^32 with carry discarded.
REQ-017 SHALL use only rs2[4:0] as shift amount for shifts; SRA SHALL fill with rs1[31], SRL/SLL SHALL fill with 0.
REQ-018 SHALL, for op 10..15, produce rd=0 with illegal=1; for all defined ops illegal SHALL be 0.
REQ-019 SHALL register the result: rd/rd_idx_out/illegal/out_valid SHALL present a transferred bundle on the cycle after its transfer edge (latency 1).
REQ-020 SHALL hold rd, rd_idx_out and illegal stable while out_valid && !out_ready.
REQ-021 SHALL retire an output on a posedge where out_valid && out_ready are both high.
REQ-022 SHALL deliver results in acceptance order, with no loss or duplication.
REQ-023 SHALL keep out_valid high once asserted until retired.
REQ-024 SHALL load the next bundle in the same cycle when an output is retired while a new bundle is transferred.
REQ-025 SHALL never assert out_valid without a prior corresponding transfer.

Reset
REQ-026 SHALL, while rst is high at a posedge, clear out_valid=0, rd=0, rd_idx_out=0, illegal=0, and empty all internal storage.
REQ-027 SHALL drop any in-flight or stalled results on mid-operation reset; no result SHALL appear after reset without a new transfer.
REQ-028 SHALL hold in_ready=0 during the reset cycle and SHALL hold in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-029 SHALL provide macro ALU_EXEC_SKID_EN.
REQ-030 SHALL, when ALU_EXEC_SKID_EN is defined, add a one-entry skid register: in_ready = !skid_valid (registered, no combinational path from out_ready); a transfer while the output is stalled SHALL fill the skid; on retire, the skid SHALL move to output on the same edge; full throughput of 1 result/cycle.
REQ-031 SHALL, when ALU_EXEC_SKID_EN is undefined, use a single output register with in_ready = !out_valid || out_ready (combinational from out_ready).
REQ-032 SHALL keep identical ordering and latency in both builds.

Verification
REQ-033 SHALL cover: op=4, rs1=0xFFFFFFFE, rs2=1 -> next cycle rd=0xFFFFFFFF, illegal=0; op=4, rs1=0x00000002, rs2=1 -> rd=0x00000001.
REQ-034 SHALL cover: op=3, rs1=0x80000000, rs2=31 -> rd=0x00000001; op=2, rs1=1, rs2=33 -> rd=0x00000002 (shift amount 1).
REQ-035 SHALL cover: op=8, rs1=0xFFFFFFFF, rs2=0 -> rd=1; op=9 with same operands -> rd=0; op=1, rs1=0, rs2=1 -> rd=0xFFFFFFFF.
REQ-036 SHALL cover: op=12 with rd_idx=7 -> rd=0, illegal=1, rd_idx_out=7.
REQ-037 SHALL cover: out_ready=0 while 3 ADDs (1+1, 2+2, 3+3) are offered -> skid build accepts 2 then in_ready=0, non-skid build accepts 1; release out_ready -> rd sequence 2, 4, 6 in order, each value stable while stalled.
REQ-038 SHALL cover: rst asserted for 1 cycle while out_valid=1 and the output is stalled -> next cycle out_valid=0, rd=0, and no stale result appears afterwards.
